// File: rtl/btb_pkg.sv
// Shared definitions for the tagged branch target buffer: counter encodings,
// allocation/reset counter values and default geometry.
package btb_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_ALLOC = CTR_WT;
    localparam ctr_t CTR_RESET = CTR_WNT;

    localparam int DEFAULT_ENTRIES = 32;
    localparam int DEFAULT_PC_W    = 32;

endpackage

// File: rtl/btb_sat_ctr.sv
// Two-bit saturating direction counter step: moves one state toward taken or
// not-taken and sticks at either end.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t next
);

    always_comb begin
        next = cur;
        case (cur)
            CTR_SNT: next = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: next = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  next = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  next = taken ? CTR_ST  : CTR_WT;
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/btb_tagged.sv
// Direct-mapped, tagged branch target buffer with 2-bit direction counters.
// Lookups are registered (one cycle); the table is read before it is written.
module btb_tagged
    import btb_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int PC_W    = DEFAULT_PC_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] lookup_pc,
    input  logic            update_valid,
    input  logic [PC_W-1:0] update_pc,
    input  logic            update_taken,
    input  logic [PC_W-1:0] update_target,
    input  logic            flush,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [PC_W-1:0]    targets [ENTRIES];
    ctr_t               ctrs    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    ctr_t             up_ctr_next;

    // Byte offset within the word never affects indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign lk_tag   = lookup_pc[PC_W-1:IDX_W+2];
    assign lk_hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctrs[lk_idx][1];

    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[PC_W-1:IDX_W+2];
    assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

    btb_sat_ctr u_sat_ctr (
        .cur   (ctrs[up_idx]),
        .taken (update_taken),
        .next  (up_ctr_next)
    );

    // Flush only drops valid bits and takes priority over any update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= CTR_RESET;
            end
        end else if (flush) begin
            valid <= '0;
        end else if (update_valid) begin
            if (up_hit) begin
                ctrs[up_idx] <= up_ctr_next;
                if (update_taken) begin
                    targets[up_idx] <= update_target;
                end
            end else if (update_taken) begin
                valid[up_idx]   <= 1'b1;
                tags[up_idx]    <= up_tag;
                targets[up_idx] <= update_target;
                ctrs[up_idx]    <= CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_hit    <= lk_hit;
            pred_taken  <= lk_taken;
            pred_target <= lk_taken ? targets[lk_idx] : lookup_pc + PC_W'(4);
        end
    end

endmodule

// File: tb/tb_btb_tagged.sv
// Self-checking bench for btb_tagged: directed scenarios with literal
// expectations, then random traffic against a behavioural table model.
module tb_btb_tagged;

    logic        clk;
    logic        reset_n;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        flush;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [32];
    logic [24:0] m_tag   [32];
    logic [31:0] m_tgt   [32];
    int          m_ctr   [32];

    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;

    btb_tagged #(.ENTRIES(32), .PC_W(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lookup_pc     (lookup_pc),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_taken  (update_taken),
        .update_target (update_target),
        .flush         (flush),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic void model_predict(input logic [31:0] pc);
        int          idx;
        logic [24:0] tag;
        idx        = int'((pc / 4) % 32);
        tag        = 25'(pc / 128);
        exp_hit    = m_valid[idx] && (m_tag[idx] == tag);
        exp_taken  = exp_hit && (m_ctr[idx] >= 2);
        exp_target = exp_taken ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_apply();
        int          idx;
        logic [24:0] tag;
        idx = int'((update_pc / 4) % 32);
        tag = 25'(update_pc / 128);
        if (flush) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        end else if (update_valid) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (update_taken) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                    m_tgt[idx] = update_target;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (update_taken) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_tgt[idx]   = update_target;
                m_ctr[idx]   = 2;
            end
        end
    endfunction

    task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic fl);
        lookup_pc     = lpc;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utgt;
        flush         = fl;
    endtask

    // Advance one cycle, keeping the model in step with whatever is driven.
    task automatic tick();
        model_predict(lookup_pc);
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        drive(32'h0000_0100, 1'b0, '0, 1'b0, '0, 1'b0);
        #12;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got hit=%0b taken=%0b target=%h expected 0/0/00000000",
                     pred_hit, pred_taken, pred_target);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0000_0104}) begin
            n_fail++;
            $display("[TB] FAIL reset_first_lookup: got hit=%0b taken=%0b target=%h expected 0/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_alloc();
        drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        tick();
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h200}) begin
            n_fail++;
            $display("[TB] FAIL alloc_hit: got hit=%0b taken=%0b target=%h expected 1/1/00000200",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h180, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h184}) begin
            n_fail++;
            $display("[TB] FAIL alloc_tag_miss: got hit=%0b taken=%0b target=%h expected 0/0/00000184",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_counter();
        drive(32'h0, 1'b1, 32'h100, 1'b0, 32'hDEAD_0000, 1'b0);
        tick();
        tick();
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h104}) begin
            n_fail++;
            $display("[TB] FAIL counter_down: got hit=%0b taken=%0b target=%h expected 1/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h0, 1'b1, 32'h100, 1'b0, '0, 1'b0);
        tick();
        // From a saturated 00, one taken step must still predict not-taken.
        drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h240, 1'b0);
        tick();
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h104}) begin
            n_fail++;
            $display("[TB] FAIL counter_saturate: got hit=%0b taken=%0b target=%h expected 1/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h260, 1'b0);
        tick();
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h260}) begin
            n_fail++;
            $display("[TB] FAIL counter_up: got hit=%0b taken=%0b target=%h expected 1/1/00000260",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_read_before_write();
        drive(32'h0, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("[TB] FAIL rbw_same_cycle: got hit=%0b taken=%0b target=%h expected 0/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h300}) begin
            n_fail++;
            $display("[TB] FAIL rbw_next_cycle: got hit=%0b taken=%0b target=%h expected 1/1/00000300",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_flush();
        drive(32'h0, 1'b1, 32'h204, 1'b1, 32'h500, 1'b0);
        tick();
        drive(32'h204, 1'b1, 32'h308, 1'b1, 32'h600, 1'b1);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h500}) begin
            n_fail++;
            $display("[TB] FAIL flush_cycle_lookup: got hit=%0b taken=%0b target=%h expected 1/1/00000500",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h100, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h104}) begin
            n_fail++;
            $display("[TB] FAIL flush_miss_100: got hit=%0b taken=%0b target=%h expected 0/0/00000104",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h204, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h208}) begin
            n_fail++;
            $display("[TB] FAIL flush_miss_204: got hit=%0b taken=%0b target=%h expected 0/0/00000208",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h308, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h30C}) begin
            n_fail++;
            $display("[TB] FAIL flush_drops_update: got hit=%0b taken=%0b target=%h expected 0/0/0000030c",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        drive(32'hFFFF_FFFC, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL wrap_target: got hit=%0b taken=%0b target=%h expected 0/0/00000000",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h0, 1'b1, 32'h400, 1'b1, 32'h700, 1'b0);
        tick();
        drive(32'h400, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h700}) begin
            n_fail++;
            $display("[TB] FAIL prereset_hit: got hit=%0b taken=%0b target=%h expected 1/1/00000700",
                     pred_hit, pred_taken, pred_target);
        end
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL async_reset_clear: got hit=%0b taken=%0b target=%h expected 0/0/00000000",
                     pred_hit, pred_taken, pred_target);
        end
        // Hold reset across an edge with an update pending; it must be discarded.
        drive(32'h400, 1'b1, 32'h480, 1'b1, 32'h800, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        drive(32'h480, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h484}) begin
            n_fail++;
            $display("[TB] FAIL reset_drops_update: got hit=%0b taken=%0b target=%h expected 0/0/00000484",
                     pred_hit, pred_taken, pred_target);
        end
        drive(32'h400, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        n_checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h404}) begin
            n_fail++;
            $display("[TB] FAIL reset_clears_entry: got hit=%0b taken=%0b target=%h expected 0/0/00000404",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 9) == 0) begin
            pc = $urandom;
        end else begin
            pc = (32'($urandom_range(0, 3)) * 4) + (32'($urandom_range(0, 2)) * 128)
                 + 32'($urandom_range(0, 3));
        end
        return pc;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(pick_pc(), ($urandom_range(0, 1) == 1), pick_pc(), ($urandom_range(0, 2) != 0),
                  $urandom, ($urandom_range(0, 29) == 0));
            tick();
            n_checks++;
            if ({pred_hit, pred_taken, pred_target} !== {exp_hit, exp_taken, exp_target}) begin
                n_fail++;
                $display("[TB] FAIL random_%0d: got hit=%0b taken=%0b target=%h expected %0b/%0b/%h",
                         n, pred_hit, pred_taken, pred_target, exp_hit, exp_taken, exp_target);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_read_before_write();
        test_flush();
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btb_tagged.md
BTB_TAGGED -- requirements
Module: btb_tagged

Interface
REQ-001 Parameter: ENTRIES, 32, number of direct-mapped entries; power of two, >= 2; IDX_W = log2(ENTRIES).
REQ-002 Parameter: PC_W, 32, program-counter and target width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 lookup_pc  input  PC_W  fetch PC to predict.
REQ-006 update_valid  input  1  resolved branch/jump update strobe.
REQ-007 update_pc  input  PC_W  PC of the resolved instruction.
REQ-008 update_taken  input  1  resolved direction, 1 = taken.
REQ-009 update_target  input  PC_W  resolved target address.
REQ-010 flush  input  1  invalidate all entries.
REQ-011 pred_hit  output  1  registered; valid entry with matching tag.
REQ-012 pred_taken  output  1  registered; predicted taken.
REQ-013 pred_target  output  PC_W  registered; predicted next PC.

Function
REQ-014 Index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
REQ-015 Per entry: valid bit, tag, target, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 Lookup latency is 1 cycle: outputs at edge N+1 reflect lookup_pc and table state sampled at edge N.
REQ-017 pred_hit = valid & tag match; pred_taken = pred_hit & counter[1].
REQ-018 pred_target = stored target when pred_taken, else lookup_pc + 4 (modulo 2^PC_W, wrap-around allowed).
REQ-019 Update on hit (valid & tag match at update index): counter +1 if taken (saturate at 11), -1 if not taken (saturate at 00); target overwritten only when taken.
REQ-020 Update on miss with update_taken=1: allocate/replace entry; valid=1, tag, target written, counter=10.
REQ-021 Update on miss with update_taken=0: no table change.
REQ-022 Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write).
REQ-023 flush: clears every valid bit at next edge; tags, targets, and counters untouched.
REQ-024 flush and update_valid in the same cycle: flush wins; the update is dropped.
REQ-025 Lookup in the flush cycle returns pre-flush contents; lookups from the following cycle miss.
REQ-026 Updates to distinct indices are independent; one update per cycle maximum.

Reset
REQ-027 reset_n low asynchronously clears all valid bits, sets all counters to 01, and zeroes all tags and targets.
REQ-028 During reset: pred_hit=0, pred_taken=0, pred_target=0.
REQ-029 Reset asserted mid-operation discards any in-flight update; the first lookup after deassertion misses.

Structure
REQ-030 Shared package btb_pkg holds the counter encodings (SNT/WNT/WT/ST), the counter allocation value, and the default ENTRIES/PC_W constants.
REQ-031 One sub-module, btb_sat_ctr: 2-bit saturating update (inputs cur, taken; output next), purely combinational, instantiated once on the update path.
REQ-032 Table storage is flop arrays indexed by IDX_W; no SRAM macro.

Verification (ENTRIES=32, PC_W=32)
REQ-033 Reset, then lookup 0x0000_0100 -> next cycle pred_hit=0, pred_taken=0, pred_target=0x0000_0104.
REQ-034 Update pc=0x100 taken target=0x200, then lookup 0x100 -> hit=1, taken=1, target=0x200; lookup 0x180 (same index, tag differs) -> hit=0, target=0x184.
REQ-035 After the REQ-034 allocation, send two not-taken updates to 0x100 -> counter 10->01->00; lookup 0x100 -> hit=1, taken=0, target=0x104; one more not-taken -> counter remains 00.
REQ-036 Same-cycle lookup 0x100 and taken update 0x100 target 0x300 on an empty table -> that lookup misses; next lookup hits with target 0x300.
REQ-037 Populate 0x100 and 0x204, then assert flush together with a taken update to 0x308 -> both later lookups miss; 0x308 also misses.
REQ-038 Lookup 0xFFFF_FFFC on a miss -> pred_target=0x0000_0000; pulsing reset_n low between clock edges -> outputs clear immediately, without waiting for an edge.
